skew_addr_gen: RTL and testbench

Parametrised successor to the fixed 8-group skewed SRAM read-address selector that feeds the systolic array's weight and data queues. The block owns its own serial counter and a start/busy/done handshake, and latches per-run weight and data base addresses. It supports stall (hold) and flags each group's valid window. It sits between the top-level controller and the weight/data SRAM read ports.

---
 rtl/tpu_addr_pkg.sv | 25 ++
 rtl/skew_win.sv | 35 +++
 rtl/skew_addr_gen.sv | 134 +++++++++++++
 tb/tb_skew_addr_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_addr_pkg.sv
// Shared types and parameter derivations for the skewed SRAM read-address generator.
package tpu_addr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned IDLE_ADDR_DEF = 127;

  function automatic int unsigned calc_last(input int unsigned num_grp,
                                            input int unsigned grp_skew,
                                            input int unsigned run_len);
    return (num_grp - 1) * grp_skew + run_len - 1;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned num_grp,
                                             input int unsigned grp_skew,
                                             input int unsigned run_len);
    int unsigned w;
    w = $clog2(calc_last(num_grp, grp_skew, run_len) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/skew_win.sv
// Per-group window decode: checks whether the serial count falls in this group's window
// and forms the base+offset addresses for weight and data sharing one compare.
module skew_win
  import tpu_addr_pkg::*;
#(
  parameter int unsigned GRP_IDX  = 0,
  parameter int unsigned GRP_SKEW = 4,
  parameter int unsigned RUN_LEN  = 99,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned CNT_W    = 7
) (
  input  logic [CNT_W-1:0]  cnt,
  input  logic [ADDR_W-1:0] base_w,
  input  logic [ADDR_W-1:0] base_d,
  output logic [ADDR_W-1:0] addr_w,
  output logic [ADDR_W-1:0] addr_d,
  output logic              in_win
);

  localparam logic [CNT_W:0]   LO   = (CNT_W+1)'(GRP_IDX * GRP_SKEW);
  localparam logic [CNT_W-1:0] SPAN = CNT_W'(RUN_LEN - 1);

  logic [CNT_W:0]   diff;
  logic [CNT_W-1:0] off;
  logic [ADDR_W-1:0] off_a;

  // The extra borrow bit flags cnt below the window start without a constant compare.
  assign diff   = {1'b0, cnt} - LO;
  assign off    = diff[CNT_W-1:0];
  assign in_win = ~diff[CNT_W] && (off <= SPAN);
  assign off_a  = ADDR_W'(off);
  assign addr_w = base_w + off_a;
  assign addr_d = base_d + off_a;

endmodule

// File: rtl/skew_addr_gen.sv
// Skewed weight/data SRAM read-address generator: start/busy/done run control, stallable
// serial counter, per-group windows and registered address outputs.
module skew_addr_gen
  import tpu_addr_pkg::*;
#(
  parameter int unsigned NUM_GRP   = 8,
  parameter int unsigned GRP_SKEW  = 4,
  parameter int unsigned RUN_LEN   = 99,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned IDLE_ADDR = IDLE_ADDR_DEF
) (
  input  logic                      clk,
  input  logic                      srstn,
  input  logic                      start,
  input  logic                      stall,
  input  logic [ADDR_W-1:0]         base_w,
  input  logic [ADDR_W-1:0]         base_d,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_GRP-1:0]        grp_vld,
  output logic [NUM_GRP*ADDR_W-1:0] sram_raddr_w,
  output logic [NUM_GRP*ADDR_W-1:0] sram_raddr_d
);

  localparam int unsigned       CNT_W  = calc_cnt_w(NUM_GRP, GRP_SKEW, RUN_LEN);
  localparam int unsigned       LAST_I = calc_last(NUM_GRP, GRP_SKEW, RUN_LEN);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(LAST_I);
  localparam logic [ADDR_W-1:0] IDLE_A = ADDR_W'(IDLE_ADDR);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] base_w_q, base_d_q;
  logic              load_base;
  logic              done_nx;

  logic [ADDR_W-1:0]         win_w [NUM_GRP];
  logic [ADDR_W-1:0]         win_d [NUM_GRP];
  logic [NUM_GRP-1:0]        win_in;
  logic [NUM_GRP-1:0]        vld_nx;
  logic [NUM_GRP*ADDR_W-1:0] aw_nx, ad_nx;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load_base = 1'b0;
    done_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx  = RUN;
          cnt_nx    = '0;
          load_base = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (cnt == LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state    <= IDLE;
      cnt      <= '0;
      base_w_q <= '0;
      base_d_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load_base) begin
        base_w_q <= base_w;
        base_d_q <= base_d;
      end
    end
  end

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    skew_win #(
      .GRP_IDX (g),
      .GRP_SKEW(GRP_SKEW),
      .RUN_LEN (RUN_LEN),
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W)
    ) u_win (
      .cnt   (cnt),
      .base_w(base_w_q),
      .base_d(base_d_q),
      .addr_w(win_w[g]),
      .addr_d(win_d[g]),
      .in_win(win_in[g])
    );
  end

  always_comb begin
    vld_nx = '0;
    aw_nx  = {NUM_GRP{IDLE_A}};
    ad_nx  = {NUM_GRP{IDLE_A}};
    if (state == RUN) begin
      for (int unsigned g = 0; g < NUM_GRP; g++) begin
        if (win_in[g]) begin
          vld_nx[g]                = 1'b1;
          aw_nx[g*ADDR_W +: ADDR_W] = win_w[g];
          ad_nx[g*ADDR_W +: ADDR_W] = win_d[g];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      grp_vld      <= '0;
      sram_raddr_w <= {NUM_GRP{IDLE_A}};
      sram_raddr_d <= {NUM_GRP{IDLE_A}};
      done         <= 1'b0;
    end else begin
      grp_vld      <= vld_nx;
      sram_raddr_w <= aw_nx;
      sram_raddr_d <= ad_nx;
      done         <= done_nx;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_skew_addr_gen.sv
// Self-checking bench: default (8 groups) and small (4x2x5) configurations share stimulus,
// each compared every cycle against a serial-position model, plus pinned literal checks.
module tb_skew_addr_gen;

  logic       clk = 1'b0;
  logic       srstn = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [9:0] base_w = '0;
  logic [9:0] base_d = '0;

  always #5 clk = ~clk;

  logic        busy8, done8, busy4, done4;
  logic [7:0]  vld8;
  logic [3:0]  vld4;
  logic [79:0] w8, d8;
  logic [39:0] w4, d4;

  skew_addr_gen dut8 (
    .clk(clk), .srstn(srstn), .start(start), .stall(stall),
    .base_w(base_w), .base_d(base_d), .busy(busy8), .done(done8),
    .grp_vld(vld8), .sram_raddr_w(w8), .sram_raddr_d(d8)
  );

  skew_addr_gen #(
    .NUM_GRP(4), .GRP_SKEW(2), .RUN_LEN(5), .ADDR_W(10), .IDLE_ADDR(127)
  ) dut4 (
    .clk(clk), .srstn(srstn), .start(start), .stall(stall),
    .base_w(base_w), .base_d(base_d), .busy(busy4), .done(done4),
    .grp_vld(vld4), .sram_raddr_w(w4), .sram_raddr_d(d4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int ng(input int c);   return (c == 0) ? 8 : 4;    endfunction
  function automatic int sk(input int c);   return (c == 0) ? 4 : 2;    endfunction
  function automatic int rl(input int c);   return (c == 0) ? 99 : 5;   endfunction
  function automatic int lst(input int c);  return (ng(c) - 1) * sk(c) + rl(c) - 1; endfunction

  // Model: a run is a walk of serial position 0..LAST; each edge registers the addresses
  // of the current position and advances unless stalled.
  bit          m_run [2];
  int          m_pos [2];
  int          m_bw  [2];
  int          m_bd  [2];
  logic [79:0] e_w [2];
  logic [79:0] e_d [2];
  logic [7:0]  e_v [2];
  logic        e_done [2];
  logic        e_busy [2];

  logic [79:0] a_w [2];
  logic [79:0] a_d [2];
  logic [7:0]  a_v [2];
  logic        a_done [2];
  logic        a_busy [2];

  always_comb begin
    a_w[0] = w8;  a_w[1] = {40'd0, w4};
    a_d[0] = d8;  a_d[1] = {40'd0, d4};
    a_v[0] = vld8; a_v[1] = {4'd0, vld4};
    a_done[0] = done8; a_done[1] = done4;
    a_busy[0] = busy8; a_busy[1] = busy4;
  end

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      e_w[c] = '0;
      e_d[c] = '0;
      e_v[c] = '0;
      e_done[c] = 1'b0;
      for (int g = 0; g < ng(c); g++) begin
        e_w[c][g*10 +: 10] = 10'd127;
        e_d[c][g*10 +: 10] = 10'd127;
      end
      if (!srstn) begin
        m_run[c] = 1'b0;
        m_pos[c] = 0;
      end else if (m_run[c]) begin
        for (int g = 0; g < ng(c); g++) begin
          int off;
          off = m_pos[c] - g * sk(c);
          if (off >= 0 && off < rl(c)) begin
            e_w[c][g*10 +: 10] = 10'((m_bw[c] + off) % 1024);
            e_d[c][g*10 +: 10] = 10'((m_bd[c] + off) % 1024);
            e_v[c][g] = 1'b1;
          end
        end
        e_done[c] = (m_pos[c] == lst(c)) && !stall;
        if (!stall) begin
          if (m_pos[c] == lst(c)) m_run[c] = 1'b0;
          else m_pos[c] = m_pos[c] + 1;
        end
      end else if (start) begin
        m_run[c] = 1'b1;
        m_pos[c] = 0;
        m_bw[c]  = int'(base_w);
        m_bd[c]  = int'(base_d);
      end
      e_busy[c] = m_run[c];
    end
    #1;
    for (int c = 0; c < 2; c++) begin
      chk((c == 0) ? "m8_addr_w" : "m4_addr_w", a_w[c], e_w[c]);
      chk((c == 0) ? "m8_addr_d" : "m4_addr_d", a_d[c], e_d[c]);
      chk((c == 0) ? "m8_vld"    : "m4_vld",    80'(a_v[c]), 80'(e_v[c]));
      chk((c == 0) ? "m8_done"   : "m4_done",   80'(a_done[c]), 80'(e_done[c]));
      chk((c == 0) ? "m8_busy"   : "m4_busy",   80'(a_busy[c]), 80'(e_busy[c]));
    end
  end

  task automatic start_run(input logic [9:0] bw, input logic [9:0] bd);
    @(negedge clk);
    base_w = bw;
    base_d = bd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_w8"}, w8, {8{10'd127}});
    chk({name, "_d8"}, d8, {8{10'd127}});
    chk({name, "_w4"}, 80'(w4), 80'({4{10'd127}}));
    chk({name, "_vld"}, 80'({vld8, vld4}), 80'd0);
    chk({name, "_ctl"}, 80'({busy8, done8, busy4, done4}), 80'd0);
  endtask

  initial begin
    int dt, dt2;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    srstn = 1'b1;

    // Plain run from base 0.
    start_run(10'd0, 10'd0);
    for (int t = 1; t <= 127; t++) begin
      @(posedge clk); #1;
      if (t == 1)   chk("t1_g0", 80'({vld8, w8[9:0]}), 80'({8'h01, 10'd0}));
      if (t == 28)  chk("t1_g7_pre", 80'({vld8[7], w8[79:70]}), 80'({1'b0, 10'd127}));
      if (t == 29)  chk("t1_g7_first", 80'({vld8[7], w8[79:70]}), 80'({1'b1, 10'd0}));
      if (t == 99)  chk("t1_g0_last", 80'(w8[9:0]), 80'd98);
      if (t == 100) chk("t1_g0_after", 80'({vld8[0], w8[9:0]}), 80'({1'b0, 10'd127}));
      if (t == 6)   chk("s4_g3_pre", 80'(vld4[3]), 80'd0);
      if (t == 7)   chk("s4_g3_first", 80'({vld4[3], w4[39:30]}), 80'({1'b1, 10'd0}));
      if (t == 11)  chk("s4_done", 80'({done4, w4[39:30]}), 80'({1'b1, 10'd4}));
      if (t == 12)  chk("s4_idle", 80'({busy4, vld4}), 80'd0);
      if (t == 126) chk("t1_busy_last", 80'({busy8, done8}), 80'({1'b1, 1'b0}));
      if (t == 127) chk("t1_done", 80'({busy8, done8, w8[79:70]}), 80'({1'b0, 1'b1, 10'd98}));
    end

    // Weight base near the top of the address space wraps modulo 2^10.
    start_run(10'd1000, 10'd5);
    for (int t = 1; t <= 130; t++) begin
      @(posedge clk); #1;
      if (t == 1)  chk("t2_first", 80'({w8[9:0], d8[9:0]}), 80'({10'd1000, 10'd5}));
      if (t == 24) chk("t2_w_top", 80'(w8[9:0]), 80'd1023);
      if (t == 25) chk("t2_wrap", 80'({w8[9:0], d8[9:0]}), 80'({10'd0, 10'd29}));
      if (t == 99) chk("t2_last", 80'({w8[9:0], d8[9:0]}), 80'({10'd74, 10'd103}));
    end

    // Three-cycle stall while the counter sits at 50.
    start_run(10'd200, 10'd300);
    dt = -1;
    for (int t = 1; t <= 140; t++) begin
      @(posedge clk); #1;
      if (done8 && dt < 0) dt = t;
      if (t == 54) chk("t3_hold", 80'(w8[9:0]), 80'd250);
      if (t == 55) chk("t3_resume", 80'(w8[9:0]), 80'd251);
      @(negedge clk);
      stall = (t >= 50 && t <= 52);
    end
    stall = 1'b0;
    chk("t3_done_cycle", 80'(dt), 80'd130);

    // Start during a run is ignored; start while done is high is accepted.
    start_run(10'd10, 10'd20);
    dt = -1;
    dt2 = -1;
    for (int t = 1; t <= 260; t++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (dt < 0) dt = t;
        else if (dt2 < 0) dt2 = t;
      end
      if (t == 12)  chk("t4_no_restart", 80'(w8[9:0]), 80'd21);
      if (t == 128) chk("t4_gap", 80'({busy8, vld8[0], w8[9:0]}), 80'({1'b1, 1'b0, 10'd127}));
      if (t == 129) chk("t4_b2b", 80'({vld8[0], w8[9:0], d8[9:0]}), 80'({1'b1, 10'd500, 10'd600}));
      @(negedge clk);
      start = (t == 10) || (t == 127 && done8);
      if (t == 10) begin base_w = 10'd999; base_d = 10'd999; end
      if (t == 127) begin base_w = 10'd500; base_d = 10'd600; end
    end
    start = 1'b0;
    chk("t4_done1", 80'(dt), 80'd127);
    chk("t4_done2", 80'(dt2), 80'd255);

    // Asynchronous reset mid-run.
    start_run(10'd30, 10'd40);
    repeat (60) @(posedge clk);
    @(negedge clk);
    srstn = 1'b0;
    #1;
    chk_idle("t5_async");
    repeat (2) @(negedge clk);
    srstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_stay_idle", 80'({busy8, done8, vld8}), 80'd0);

    // Randomized runs with stalls, stray starts and rare resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 15) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      base_w = 10'($urandom);
      base_d = 10'($urandom);
      srstn  = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    srstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
